// File: rtl/dump_pkg.sv
// ============================================================================
// Module : dump_pkg
// Brief  : Shared constants, FSM state type and source tags for the dump unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dump_pkg;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 5;
   localparam int NREGS  = 32;
   localparam int NMEM   = 32;

   localparam logic SRC_REG = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN_REG = 3'd1,
      SCAN_MEM = 3'd2,
      DRAIN    = 3'd3,
      DONE     = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/dump_out_reg.sv
// ============================================================================
// Module : dump_out_reg
// Brief  : Single-entry valid/ready holding register with an explicit load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dump_out_reg #(
   parameter int W = 38
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // The caller only asserts load when the slot is empty or being drained.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/state_dump_unit.sv
// ============================================================================
// Module : state_dump_unit
// Brief  : Walks register file then data memory, streaming tagged words out
//          over valid/ready while accumulating a 32-bit checksum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module state_dump_unit
   import dump_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_sel,
   output logic [IDX_W-1:0]  rd_idx,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_is_mem,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam int              PAYLOAD_W = 1 + IDX_W + DATA_W;
   localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NREGS - 1);
   localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NMEM - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                sel_q, sel_d;
   logic [DATA_W-1:0]   cks_q, cks_d;

   logic                w_scanning;
   logic                w_load;
   logic                w_start_ok;
   logic                w_last_reg;
   logic                w_last_mem;
   logic [DATA_W-1:0]   w_rdata;
   logic [PAYLOAD_W-1:0] w_payload_in;
   logic [PAYLOAD_W-1:0] w_payload_out;

   assign w_scanning = (state_q == SCAN_REG) || (state_q == SCAN_MEM);
   assign w_load     = w_scanning && (!out_valid || out_ready);
   assign w_start_ok = (state_q == IDLE) && start;
   assign w_last_reg = (sel_q == SRC_REG) && (idx_q == LAST_REG);
   assign w_last_mem = (sel_q == SRC_MEM) && (idx_q == LAST_MEM);
   assign w_rdata    = (sel_q == SRC_MEM) ? mem_rdata : reg_rdata;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start) state_d = SCAN_REG;
         SCAN_REG: if (w_load && w_last_reg) state_d = SCAN_MEM;
         SCAN_MEM: if (w_load && w_last_mem) state_d = DRAIN;
         DRAIN:    if (out_valid && out_ready) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         SCAN_REG, SCAN_MEM, DRAIN: busy = 1'b1;
         DONE:                      done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ---------------- Read pointer and checksum ----------------
   always_comb begin
      idx_d = idx_q;
      sel_d = sel_q;
      cks_d = cks_q;
      if (w_start_ok) begin
         idx_d = '0;
         sel_d = SRC_REG;
         cks_d = '0;
      end else if (w_load) begin
         cks_d = cks_q + w_rdata;
         // Pointer parks on the final memory entry once the scan is complete.
         if (w_last_reg) begin
            idx_d = '0;
            sel_d = SRC_MEM;
         end else if (!w_last_mem) begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         sel_q <= SRC_REG;
         cks_q <= '0;
      end else begin
         idx_q <= idx_d;
         sel_q <= sel_d;
         cks_q <= cks_d;
      end
   end

   assign rd_sel   = sel_q;
   assign rd_idx   = idx_q;
   assign checksum = cks_q;

   // ---------------- Output holding register ----------------
   assign w_payload_in = {sel_q, idx_q, w_rdata};

   dump_out_reg #(
      .W (PAYLOAD_W)
   ) u_out_reg (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (w_load),
      .data_i  (w_payload_in),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (w_payload_out)
   );

   assign out_is_mem = w_payload_out[PAYLOAD_W-1];
   assign out_idx    = w_payload_out[DATA_W +: IDX_W];
   assign out_data   = w_payload_out[DATA_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_state_dump_unit.sv
// ============================================================================
// Module : tb_state_dump_unit
// Brief  : Self-checking bench for state_dump_unit against a word-list model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_state_dump_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        out_ready;
   logic        rd_sel;
   logic [4:0]  rd_idx;
   logic [31:0] reg_rdata;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_is_mem;
   logic [4:0]  out_idx;
   logic [31:0] out_data;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   logic [31:0] regm [32];
   logic [31:0] memm [32];
   logic [37:0] exp_w [64];
   logic [31:0] exp_ck;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign reg_rdata = regm[rd_idx];
   assign mem_rdata = memm[rd_idx];

   state_dump_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rd_sel     (rd_sel),
      .rd_idx     (rd_idx),
      .reg_rdata  (reg_rdata),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_is_mem (out_is_mem),
      .out_idx    (out_idx),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: the dump is simply the register list followed by the memory list.
   task automatic load_data(input int mode);
      exp_ck = '0;
      for (int i = 0; i < 32; i++) begin
         case (mode)
            0: begin regm[i] = 32'(i); memm[i] = 32'(100 + i); end
            1: begin regm[i] = 32'hFFFF_FFFF; memm[i] = 32'hFFFF_FFFF; end
            default: begin regm[i] = $urandom; memm[i] = $urandom; end
         endcase
      end
      for (int i = 0; i < 32; i++) begin
         exp_w[i]      = {1'b0, 5'(i), regm[i]};
         exp_w[32 + i] = {1'b1, 5'(i), memm[i]};
         exp_ck        = exp_ck + regm[i] + memm[i];
      end
   endtask

   task automatic check_reset();
      chk("rst_busy",    64'(busy),       64'(0));
      chk("rst_done",    64'(done),       64'(0));
      chk("rst_valid",   64'(out_valid),  64'(0));
      chk("rst_is_mem",  64'(out_is_mem), 64'(0));
      chk("rst_out_idx", 64'(out_idx),    64'(0));
      chk("rst_data",    64'(out_data),   64'(0));
      chk("rst_ck",      64'(checksum),   64'(0));
      chk("rst_rd_sel",  64'(rd_sel),     64'(0));
      chk("rst_rd_idx",  64'(rd_idx),     64'(0));
   endtask

   // rmode: 0 ready high, 1 toggling, 2 low for 10 stalled cycles, 3 random
   task automatic run_dump(input int rmode, input int s2_word, input int abort_word);
      int          n;
      int          cyc;
      bit          prev_stall;
      bit          s2;
      bit          fin;
      logic [37:0] held;
      logic [37:0] cur;
      n = 0; s2 = 1'b0; fin = 1'b0; prev_stall = 1'b0; held = '0;
      @(negedge clk);
      start     = 1'b1;
      out_ready = (rmode != 2);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      chk("start_busy",  64'(busy),      64'(1));
      chk("start_ck",    64'(checksum),  64'(0));
      chk("start_valid", 64'(out_valid), 64'(0));
      while (cyc < 600 && !fin) begin
         cur = {out_is_mem, out_idx, out_data};
         if (abort_word >= 0 && n == abort_word) begin
            rst = 1'b1;
            #1;
            check_reset();
            @(negedge clk);
            rst = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("abort_no_done", 64'(done), 64'(0));
               chk("abort_idle",    64'(busy), 64'(0));
            end
            return;
         end
         start = 1'b0;
         if (s2_word >= 0 && n == s2_word && !s2) begin
            start = 1'b1;
            s2    = 1'b1;
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            2:       out_ready = (cyc >= 12);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (done) begin
            chk("done_count", 64'(n),        64'(64));
            chk("done_ck",    64'(checksum), 64'(exp_ck));
            chk("done_busy",  64'(busy),     64'(0));
            if (rmode == 0) chk("done_cycle", 64'(cyc), 64'(66));
            @(negedge clk);
            chk("done_pulse", 64'(done),      64'(0));
            chk("idle_valid", 64'(out_valid), 64'(0));
            chk("ck_hold",    64'(checksum),  64'(exp_ck));
            fin = 1'b1;
         end else begin
            chk("busy_run", 64'(busy), 64'(1));
            if (prev_stall) begin
               chk("stall_valid", 64'(out_valid), 64'(1));
               chk("stall_hold",  64'(cur),       64'(held));
            end
            if (rmode == 2 && cyc >= 2 && cyc <= 11) begin
               chk("low_rd_idx", 64'(rd_idx),   64'(1));
               chk("low_ck",     64'(checksum), 64'(exp_w[0][31:0]));
               chk("low_word",   64'(cur),      64'(exp_w[0]));
            end
            if (out_valid && out_ready) begin
               if (n < 64) chk("word", 64'(cur), 64'(exp_w[n]));
               else        chk("extra_word", 64'(n), 64'(63));
               if (rmode == 0) chk("latency", 64'(cyc), 64'(n + 2));
               n++;
            end
            prev_stall = out_valid && !out_ready;
            held       = cur;
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk("timeout_done", 64'(done), 64'(1));
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      load_data(0);
      #1;
      check_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset();

      run_dump(0, -1, -1);
      chk("basic_ck", 64'(checksum), 64'(32'd4192));
      run_dump(1, -1, -1);
      run_dump(2, -1, -1);
      run_dump(0, 20, -1);
      run_dump(0, -1, 40);
      run_dump(0, -1, -1);

      load_data(1);
      run_dump(0, -1, -1);
      chk("wrap_ck", 64'(checksum), 64'(32'hFFFF_FFC0));

      for (int r = 0; r < 3; r++) begin
         load_data(2);
         run_dump(3, -1, -1);
      end
      load_data(2);
      run_dump(1, 30, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
